// File: rtl/debug_data_receiver_pkg.sv
// Shared definitions for the debug serial link (receiver and transmitter).
// Holds the word width and the receiver state encoding.
package debug_link_pkg;

    localparam int DBG_WORD_W = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/debug_data_receiver_if.sv
// Serial-link pins plus the parallel word output of the debug receiver.
// master = link driver / word consumer, slave = receiver.
interface debug_data_receiver_if #(
    parameter int WIDTH = debug_link_pkg::DBG_WORD_W
);
    logic             ser_clk;
    logic             ser_frame;
    logic             ser_data;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output ser_clk, ser_frame, ser_data,
        input  data_out, data_valid, frame_err, busy
    );

    modport slave (
        input  ser_clk, ser_frame, ser_data,
        output data_out, data_valid, frame_err, busy
    );
endinterface

// File: rtl/debug_data_receiver_sync_edge.sv
// Two-flop synchronizer with a previous-value register and edge strobes.
// RST_VAL sets the reset level of every flop in the chain.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = ~prev_q & sync_q;
    assign fall_o = prev_q & ~sync_q;
endmodule

// File: rtl/debug_data_receiver.sv
// Oversampling deserializer for the debug serial link (LSB first, one word per frame).
// Optional word/error counters are built when DEBUG_DATA_RECEIVER_STATS_EN is defined.
module debug_data_receiver
    import debug_link_pkg::*;
#(
    parameter int WIDTH = DBG_WORD_W,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    debug_data_receiver_if.slave  bus
`ifdef DEBUG_DATA_RECEIVER_STATS_EN
    ,
    output logic [15:0]           rx_word_cnt,
    output logic [15:0]           rx_err_cnt
`endif
);
    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
    // Bit order: 0 = ser_clk, 1 = ser_frame, 2 = ser_data; frame idles high after reset.
    localparam logic [2:0] SYNC_RST = 3'b010;

    logic [2:0] pin_v;
    logic [2:0] sync_v;
    logic [2:0] rise_v;
    logic [2:0] fall_v;

    assign pin_v = {bus.ser_data, bus.ser_frame, bus.ser_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            sync_edge #(.RST_VAL(SYNC_RST[gi])) u_sync (
                .clk     (clk),
                .rst     (rst),
                .async_i (pin_v[gi]),
                .sync_o  (sync_v[gi]),
                .rise_o  (rise_v[gi]),
                .fall_o  (fall_v[gi])
            );
        end
    endgenerate

    logic clk_fall, frm_rise, frm_fall, data_sync;
    assign clk_fall  = fall_v[0];
    assign frm_rise  = rise_v[1];
    assign frm_fall  = fall_v[1];
    assign data_sync = sync_v[2];

    logic unused_edges;
    assign unused_edges = ^{sync_v[1:0], rise_v[2], rise_v[0], fall_v[2]};

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            shreg_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                ovf_d = 1'b0;
                if (frm_rise) begin
                    state_d = RECV;
                    shreg_d = '0;
                end
            end
            RECV: begin
                // A sample coinciding with the frame end still belongs to this word.
                if (clk_fall) begin
                    shreg_d = {data_sync, shreg_q[WIDTH-1:1]};
                    if (cnt_q < WIDTH_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (frm_fall) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if ((cnt_q == WIDTH_CNT) && !ovf_q) begin
                    data_out_d   = shreg_q;
                    data_valid_d = 1'b1;
                end else begin
                    frame_err_d  = 1'b1;
                end
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q == RECV) || (state_q == DONE);

`ifdef DEBUG_DATA_RECEIVER_STATS_EN
    logic [15:0] word_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (data_valid_q) word_cnt_q <= word_cnt_q + 16'd1;
            if (frame_err_q)  err_cnt_q  <= err_cnt_q + 16'd1;
        end
    end

    assign rx_word_cnt = word_cnt_q;
    assign rx_err_cnt  = err_cnt_q;
`endif
endmodule

// File: tb/tb_debug_data_receiver.sv
// Scoreboard bench for debug_data_receiver: frames are generated, expected
// results queued from the link rules, and a monitor checks every output pulse.
module tb_debug_data_receiver;
    import debug_link_pkg::*;

    localparam int W = DBG_WORD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debug_data_receiver_if #(.WIDTH(W)) bus ();

`ifdef DEBUG_DATA_RECEIVER_STATS_EN
    logic [15:0] rx_word_cnt;
    logic [15:0] rx_err_cnt;
`endif

    debug_data_receiver #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DEBUG_DATA_RECEIVER_STATS_EN
        ,
        .rx_word_cnt (rx_word_cnt),
        .rx_err_cnt  (rx_err_cnt)
`endif
    );

    typedef struct {
        bit           is_err;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [W-1:0] model_last = '0;
    int           model_words = 0;
    int           model_errs = 0;
    int           checks = 0;
    int           errors = 0;
    logic         prev_pulse = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every output pulse is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_pulse <= 1'b0;
        end else begin
            if (bus.data_valid || bus.frame_err) begin
                check("exclusive", 64'(bus.data_valid & bus.frame_err), 64'd0);
                check("no_consecutive", 64'(prev_pulse), 64'd0);
                check("busy_low_at_pulse", 64'(bus.busy), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%h", bus.data_valid,
                             bus.frame_err, bus.data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check(mon_e.is_err ? "kind_err" : "kind_valid", 64'(bus.frame_err),
                          64'(mon_e.is_err));
                    check("data_out", 64'(bus.data_out), 64'(mon_e.data));
                end
            end
            prev_pulse <= bus.data_valid | bus.frame_err;
        end
    end

    task automatic do_reset(input int cycles);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #2 rst = 1'b0;
        model_last  = '0;
        model_words = 0;
        model_errs  = 0;
    endtask

    // One bit period = 2*half clk cycles; frame is high for exactly nbits periods.
    task automatic send_frame(input logic [W-1:0] word, input int nbits, input int half,
                              input int rst_bit);
        for (int k = 0; k < nbits; k++) begin
            @(posedge clk); #2;
            bus.ser_clk  = 1'b1;
            bus.ser_data = (k < W) ? word[k] : 1'($urandom_range(0, 1));
            if (k == 0) bus.ser_frame = 1'b1;
            repeat (half) @(posedge clk);
            #2 bus.ser_clk = 1'b0;
            if (k == 10 && rst_bit < 0) check("busy_mid_frame", 64'(bus.busy), 64'd1);
            if (k == rst_bit) begin
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #2 rst = 1'b0;
                model_last  = '0;
                model_words = 0;
                model_errs  = 0;
                repeat (half - 3) @(posedge clk);
            end else begin
                repeat (half - 1) @(posedge clk);
            end
        end
        if (rst_bit < 0) begin
            if (nbits == W) begin
                exp_q.push_back('{is_err: 1'b0, data: word});
                model_last = word;
                model_words++;
            end else begin
                exp_q.push_back('{is_err: 1'b1, data: model_last});
                model_errs++;
            end
        end
        @(posedge clk); #2;
        bus.ser_frame = 1'b0;
        bus.ser_data  = 1'b0;
    endtask

    task automatic gap(input int half, input int periods);
        repeat (2 * half * periods) @(posedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_data_out", 64'(bus.data_out), 64'd0);
        check("rst_data_valid", 64'(bus.data_valid), 64'd0);
        check("rst_frame_err", 64'(bus.frame_err), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
`ifdef DEBUG_DATA_RECEIVER_STATS_EN
        check("rst_word_cnt", 64'(rx_word_cnt), 64'd0);
        check("rst_err_cnt", 64'(rx_err_cnt), 64'd0);
`endif
    endtask

    task automatic check_stats();
`ifdef DEBUG_DATA_RECEIVER_STATS_EN
        check("stat_word_cnt", 64'(rx_word_cnt), 64'(model_words));
        check("stat_err_cnt", 64'(rx_err_cnt), 64'(model_errs));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ser_clk   = 1'b0;
        bus.ser_frame = 1'b0;
        bus.ser_data  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_state();
        @(posedge clk); #2 rst = 1'b0;
        gap(4, 2);

        // Nominal word at clk/8.
        send_frame(40'hA999999991, W, 4, -1);
        gap(4, 2);
        // Back-to-back with a single idle ser_clk period.
        send_frame(40'hA999999981, W, 4, -1);
        gap(4, 1);
        send_frame(40'hE999999993, W, 4, -1);
        gap(4, 2);
        // Short frame, then long frame followed by a good one.
        send_frame(40'h1234567890, W - 1, 4, -1);
        gap(4, 2);
        send_frame(40'h0FEDCBA987, W + 1, 4, -1);
        gap(4, 2);
        send_frame(40'h5A5A5AA5A5, W, 4, -1);
        gap(4, 2);
        drain();
        check_stats();

        // Reset at bit 20 with the frame held high: nothing reported, next frame decodes.
        send_frame(40'hFFFF0000FF, W, 4, 20);
        gap(4, 2);
        check("after_mid_rst_data_out", 64'(bus.data_out), 64'd0);
        send_frame(40'hC3C3C3C3C3, W, 4, -1);
        gap(4, 2);
        drain();

        // Randomized frames: varied data, length, ser_clk rate and gaps.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] w;
            int nb, hf, sel;
            w   = {8'($urandom), 32'($urandom)};
            sel = $urandom_range(0, 9);
            nb  = (sel < 6) ? W : (sel < 8) ? W - 1 - $urandom_range(0, 2) : W + 1 + $urandom_range(0, 2);
            hf  = $urandom_range(2, 5);
            send_frame(w, nb, hf, -1);
            gap(hf, $urandom_range(1, 3));
        end
        drain();
        check_stats();

        do_reset(2);
        check_reset_state();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/debug_data_receiver.md
Name: debug_data_receiver

Overview:
- Far-end deserializer for the debug serial link.
- The transmitter drives one bit per serial-clock period, LSB first, 40 bits per frame. A frame line is high for exactly the 40 bit periods of each word.
- This block oversamples ser_clk, ser_frame and ser_data in a single fast system clock domain, rebuilds each word and presents it with a one-cycle valid strobe.
- Target use: debug capture logic and board-level loopback checks of the sender.

Parameters:
- WIDTH, 40, bits per frame; must match the transmitter word width.
- CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; must be ≥4× ser_clk frequency.
- rst  input  1  synchronous, active-high reset.
- ser_clk  input  1  async serial clock from the transmitter (out_clk).
- ser_frame  input  1  async frame indicator, high while a word is shifted.
- ser_data  input  1  async serial data (sout); bit k is stable between ser_clk rising edges k and k+1.
- data_out  output  WIDTH  last good word; held until the next good word.
- data_valid  output  1  one-clk pulse when data_out updates.
- frame_err  output  1  one-clk pulse when a frame ends with bit count ≠ WIDTH.
- busy  output  1  high while in RECV or DONE.

Behaviour:
- Input conditioning
  - All three inputs pass through identical 2-FF synchronizers plus a previous-value register, so they stay mutually aligned.
  - ser_clk and ser_data sync regs reset to 0.
  - ser_frame sync and previous regs reset to 1. A frame already high at reset is therefore not seen as a start.
  - Events derived from the synchronized signals:
    - clk_fall = prev & ~cur on ser_clk.
    - frm_rise = ~prev & cur on ser_frame.
    - frm_fall = prev & ~cur on ser_frame.
- State machine
  - IDLE: cnt held at 0. frm_rise → RECV, clear cnt and shreg. frm_fall is ignored.
  - RECV:
    - On clk_fall: shreg <= {data_sync, shreg[WIDTH-1:1]}, i.e. LSB-first fill with the newest bit at the MSB.
    - If cnt < WIDTH then cnt <= cnt+1; otherwise set the ovf flag and cnt saturates.
    - On frm_fall → DONE.
    - If clk_fall and frm_fall occur in the same cycle, the sample is taken first, then → DONE.
  - DONE (one cycle):
    - If cnt == WIDTH and ovf == 0: data_out <= shreg, data_valid = 1.
    - Otherwise: frame_err = 1 and data_out is unchanged.
    - Always → IDLE; ovf cleared.
    - A frm_rise seen while in DONE is lost. The transmitter guarantees ≥1 ser_clk period between frames.
- Latency: data_valid asserts 4 clk cycles after the ser_frame pin falls (2 sync, 1 edge, 1 DONE).
- Reset values:
  - data_out = 0, data_valid = 0, frame_err = 0, busy = 0.
  - state = IDLE, cnt = 0, ovf = 0.
- Reset mid-frame: the partial word is discarded and no pulse is issued. The receiver resumes only at the next true frm_rise.
- data_valid and frame_err are mutually exclusive and never high for two consecutive cycles.
- No backpressure: the consumer must capture data_out on the data_valid pulse, or before the next frame completes.

Optional Feature:
- Macro: DEBUG_DATA_RECEIVER_STATS_EN.
- When defined, two extra outputs are added:
  - rx_word_cnt[15:0]: increments on each data_valid.
  - rx_err_cnt[15:0]: increments on each frame_err.
  - Both wrap at 16'hFFFF → 0 and clear on rst.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package debug_link_pkg:
  - DBG_WORD_W = 40.
  - State encodings IDLE = 2'd0, RECV = 2'd1, DONE = 2'd2.
  - The same width constant is to be shared with the transmitter.
- Sub-module sync_edge:
  - Contents: 2-FF synchronizer, previous register, rise/fall outputs, and a parameterised reset value.
  - Instantiated three times (ser_clk, ser_frame, ser_data) to guarantee equal delay.

Test Plan:
- Nominal word: ser_clk = clk/8, frame of 40'hA999999991 sent LSB first → exactly one data_valid, data_out = 40'hA999999991, frame_err never high.
- Back-to-back words: 40'hA999999981, then 40'hE999999993 with a one-ser_clk gap → two data_valid pulses with the correct values in order; busy drops for ≥1 cycle between them.
- Short frame: frame deasserted after 39 bits → frame_err pulse, data_out keeps its previous value, no data_valid.
- Long frame: 41 ser_clk falls inside the frame → frame_err pulse; the next correct 40-bit frame yields data_valid with the right data.
- Reset mid-frame: rst for 2 cycles at bit 20 while ser_frame stays high → no pulses for that frame; the following full frame decodes correctly.
- With DEBUG_DATA_RECEIVER_STATS_EN: 3 good frames and 1 short frame → rx_word_cnt = 3, rx_err_cnt = 1; both read 0 after rst.
